// File: rtl/ram512_pkg.sv
// ram512_pkg: shared widths, FSM encodings and port indices for the RAM512 arbiter
package ram512_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SERVE = 2'd2
  } state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer port wins a tie and moves to the loser after any grant
// Ports: clk, rst_n (async active-low), en (allow grants), req[1:0] (A=0, B=1), gnt[1:0] (one-hot or zero)
module rr_arb2 import ram512_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic r_ptr;
  always_comb gnt = !en ? 2'b00 : (&req ? (r_ptr == PORT_B ? 2'b10 : 2'b01) : req);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= PORT_A;
    else if (|gnt) r_ptr <= gnt[PORT_A] ? PORT_B : PORT_A;
endmodule

// File: rtl/ram512_arbiter.sv
// ram512_arbiter: shares the single RAM512 port between masters A and B, zero-filling the RAM after reset and on request
// Ports: clk, rst_n (async active-low), clr_req (start zero-fill), busy (clearing),
//        a_*/b_* valid/we/addr/wdata in, ready/rvalid/rdata out (1-cycle read latency),
//        ram_load/ram_address/ram_in to RAM512, ram_out from RAM512 (combinational read)
module ram512_arbiter import ram512_pkg::*; #(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, r_addr, w_addr;
  logic [DATA_W-1:0] r_din, w_din;
  logic [1:0] w_gnt;
  logic w_en, w_we, w_clear;
  assign w_clear = r_state == ST_CLEAR;
  // a clear request steals the cycle: no grant while the FSM switches to CLEAR
  assign w_en = r_state == ST_SERVE && !clr_req;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_en),
    .req  ({b_valid, a_valid}),
    .gnt  (w_gnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_START;
    else r_state <= w_next;
  always_comb
    w_next = r_state == ST_START ? (CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_SERVE) :
             w_clear ? (r_cnt == LAST ? ST_SERVE : ST_CLEAR) :
             (clr_req ? ST_CLEAR : ST_SERVE);
  // idle cycles keep the last address/data on the RAM bus
  always_comb begin
    w_we        = w_gnt[PORT_A] ? a_we : b_we;
    busy        = w_clear;
    ram_load    = w_clear || (|w_gnt && w_we);
    w_addr      = w_clear ? r_cnt : w_gnt[PORT_A] ? a_addr : w_gnt[PORT_B] ? b_addr : r_addr;
    w_din       = w_clear ? '0 : ram_load ? (w_gnt[PORT_A] ? a_wdata : b_wdata) : r_din;
    ram_address = w_addr;
    ram_in      = w_din;
    a_ready     = w_gnt[PORT_A];
    b_ready     = w_gnt[PORT_B];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_din    <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      r_cnt    <= w_clear ? r_cnt + 1'b1 : '0;
      r_addr   <= w_addr;
      r_din    <= w_din;
      a_rvalid <= a_ready && !a_we;
      b_rvalid <= b_ready && !b_we;
      if (a_ready && !a_we) a_rdata <= ram_out;
      if (b_ready && !b_we) b_rdata <= ram_out;
    end
endmodule
